// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: default widths, ALU and
// forwarding-select encodings, MIPS opcode constants and a small helper.
package id_ex_stage_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int REG_AW_DEF   = 5;
    localparam int ALUCTR_W_DEF = 3;
    localparam int CNT_W_DEF    = 16;

    // ALU control codes produced by the ID-stage controller
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

    // Operand-select encodings driven to the EX-stage operand muxes
    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    // Opcode / funct constants of the supported instruction subset
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2a;

    // Priority pick of an operand source: the younger EX/MEM result wins
    function automatic fwd_sel_e fwd_pick(input logic hit_exmem, input logic hit_memwb);
        fwd_sel_e sel;
        if (hit_exmem) begin
            sel = FWD_EXMEM;
        end else if (hit_memwb) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between the ID-stage controller/register file, the later pipeline
// stages and the ID/EX stage. master = surrounding pipeline, slave = stage.
interface id_ex_stage_if #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ALUCTR_W = 3,
    parameter int CNT_W    = 16
);
    // Decoded instruction from ID
    logic                id_RegWr;
    logic                id_RegDst;
    logic                id_ExtOp;
    logic                id_ALUsrc;
    logic                id_Branch;
    logic                id_Jump;
    logic                id_MemWr;
    logic                id_MemtoReg;
    logic [ALUCTR_W-1:0] id_ALUctr;
    logic [REG_AW-1:0]   id_rs;
    logic [REG_AW-1:0]   id_rt;
    logic [REG_AW-1:0]   id_rd;
    logic [DATA_W-1:0]   id_busA;
    logic [DATA_W-1:0]   id_busB;
    logic [DATA_W-1:0]   id_imm32;
    logic [DATA_W-1:0]   id_pc4;

    // Control-flow kill and later-stage writeback info
    logic                flush;
    logic                exmem_RegWr;
    logic                memwb_RegWr;
    logic [REG_AW-1:0]   exmem_wreg;
    logic [REG_AW-1:0]   memwb_wreg;

    // Stall controls toward PC / IF/ID
    logic                pc_wr_en;
    logic                ifid_wr_en;

    // Registered instruction toward EX
    logic                ex_RegWr;
    logic                ex_RegDst;
    logic                ex_ExtOp;
    logic                ex_ALUsrc;
    logic                ex_Branch;
    logic                ex_Jump;
    logic                ex_MemWr;
    logic                ex_MemtoReg;
    logic [ALUCTR_W-1:0] ex_ALUctr;
    logic [REG_AW-1:0]   ex_rs;
    logic [REG_AW-1:0]   ex_rt;
    logic [REG_AW-1:0]   ex_rd;
    logic [DATA_W-1:0]   ex_busA;
    logic [DATA_W-1:0]   ex_busB;
    logic [DATA_W-1:0]   ex_imm32;
    logic [DATA_W-1:0]   ex_pc4;
    logic [REG_AW-1:0]   ex_wreg;

    // Operand selects and bring-up counters
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    modport master (
        output id_RegWr, id_RegDst, id_ExtOp, id_ALUsrc, id_Branch, id_Jump,
               id_MemWr, id_MemtoReg, id_ALUctr, id_rs, id_rt, id_rd,
               id_busA, id_busB, id_imm32, id_pc4,
               flush, exmem_RegWr, memwb_RegWr, exmem_wreg, memwb_wreg,
        input  pc_wr_en, ifid_wr_en,
               ex_RegWr, ex_RegDst, ex_ExtOp, ex_ALUsrc, ex_Branch, ex_Jump,
               ex_MemWr, ex_MemtoReg, ex_ALUctr, ex_rs, ex_rt, ex_rd,
               ex_busA, ex_busB, ex_imm32, ex_pc4, ex_wreg,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_RegWr, id_RegDst, id_ExtOp, id_ALUsrc, id_Branch, id_Jump,
               id_MemWr, id_MemtoReg, id_ALUctr, id_rs, id_rt, id_rd,
               id_busA, id_busB, id_imm32, id_pc4,
               flush, exmem_RegWr, memwb_RegWr, exmem_wreg, memwb_wreg,
        output pc_wr_en, ifid_wr_en,
               ex_RegWr, ex_RegDst, ex_ExtOp, ex_ALUsrc, ex_Branch, ex_Jump,
               ex_MemWr, ex_MemtoReg, ex_ALUctr, ex_rs, ex_rt, ex_rd,
               ex_busA, ex_busB, ex_imm32, ex_pc4, ex_wreg,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Forwarding-select generator: picks the freshest producer of each EX
// source register. Register 0 is hard-wired zero and is never forwarded.
module id_ex_stage_fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] i_ex_rs,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic              i_exmem_RegWr,
    input  logic [REG_AW-1:0] i_exmem_wreg,
    input  logic              i_memwb_RegWr,
    input  logic [REG_AW-1:0] i_memwb_wreg,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b
);

    logic w_exmem_live;
    logic w_memwb_live;

    // A later stage is a candidate only if it writes a non-zero register
    always_comb begin
        w_exmem_live = i_exmem_RegWr & (i_exmem_wreg != {REG_AW{1'b0}});
        w_memwb_live = i_memwb_RegWr & (i_memwb_wreg != {REG_AW{1'b0}});
    end

    // Match each source against both stages; EX/MEM wins when both hit
    always_comb begin
        o_fwd_a = fwd_pick(w_exmem_live & (i_exmem_wreg == i_ex_rs),
                           w_memwb_live & (i_memwb_wreg == i_ex_rs));
        o_fwd_b = fwd_pick(w_exmem_live & (i_exmem_wreg == i_ex_rt),
                           w_memwb_live & (i_memwb_wreg == i_ex_rt));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbling,
// forwarding-select generation and saturating stall/flush event counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int ALUCTR_W = ALUCTR_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  io_bus
);

    // Hazard / bubble decision
    logic w_uses_rs;
    logic w_uses_rt;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_load_use;
    logic w_stall;
    logic w_bubble;

    // ID/EX state
    logic                r_ex_RegWr;
    logic                r_ex_RegDst;
    logic                r_ex_ExtOp;
    logic                r_ex_ALUsrc;
    logic                r_ex_Branch;
    logic                r_ex_Jump;
    logic                r_ex_MemWr;
    logic                r_ex_MemtoReg;
    logic [ALUCTR_W-1:0] r_ex_ALUctr;
    logic [REG_AW-1:0]   r_ex_rs;
    logic [REG_AW-1:0]   r_ex_rt;
    logic [REG_AW-1:0]   r_ex_rd;
    logic [REG_AW-1:0]   r_ex_wreg;
    logic [DATA_W-1:0]   r_ex_busA;
    logic [DATA_W-1:0]   r_ex_busB;
    logic [DATA_W-1:0]   r_ex_imm32;
    logic [DATA_W-1:0]   r_ex_pc4;

    // Event counters
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic [1:0]          w_fwd_a;
    logic [1:0]          w_fwd_b;

    // Load-use: EX holds a load whose destination (rt) the ID instruction reads
    always_comb begin
        w_uses_rs  = ~io_bus.id_Jump;
        w_uses_rt  = io_bus.id_RegDst | io_bus.id_MemWr | io_bus.id_Branch;
        w_rs_hit   = w_uses_rs & (r_ex_rt == io_bus.id_rs);
        w_rt_hit   = w_uses_rt & (r_ex_rt == io_bus.id_rt);
        w_load_use = r_ex_MemtoReg & r_ex_RegWr & (r_ex_rt != {REG_AW{1'b0}})
                   & (w_rs_hit | w_rt_hit);
        // A flush kills the dependent instruction anyway, so it must not stall
        w_stall    = w_load_use & ~io_bus.flush;
        w_bubble   = io_bus.flush | w_load_use;
    end

    // ID/EX control and register fields: bubble on flush/load-use, else capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_RegWr    <= 1'b0;
            r_ex_RegDst   <= 1'b0;
            r_ex_ExtOp    <= 1'b0;
            r_ex_ALUsrc   <= 1'b0;
            r_ex_Branch   <= 1'b0;
            r_ex_Jump     <= 1'b0;
            r_ex_MemWr    <= 1'b0;
            r_ex_MemtoReg <= 1'b0;
            r_ex_ALUctr   <= {ALUCTR_W{1'b0}};
            r_ex_rs       <= {REG_AW{1'b0}};
            r_ex_rt       <= {REG_AW{1'b0}};
            r_ex_rd       <= {REG_AW{1'b0}};
            r_ex_wreg     <= {REG_AW{1'b0}};
        end else if (w_bubble) begin
            r_ex_RegWr    <= 1'b0;
            r_ex_RegDst   <= 1'b0;
            r_ex_ExtOp    <= 1'b0;
            r_ex_ALUsrc   <= 1'b0;
            r_ex_Branch   <= 1'b0;
            r_ex_Jump     <= 1'b0;
            r_ex_MemWr    <= 1'b0;
            r_ex_MemtoReg <= 1'b0;
            r_ex_ALUctr   <= {ALUCTR_W{1'b0}};
            r_ex_rs       <= {REG_AW{1'b0}};
            r_ex_rt       <= {REG_AW{1'b0}};
            r_ex_rd       <= {REG_AW{1'b0}};
            r_ex_wreg     <= {REG_AW{1'b0}};
        end else begin
            r_ex_RegWr    <= io_bus.id_RegWr;
            r_ex_RegDst   <= io_bus.id_RegDst;
            r_ex_ExtOp    <= io_bus.id_ExtOp;
            r_ex_ALUsrc   <= io_bus.id_ALUsrc;
            r_ex_Branch   <= io_bus.id_Branch;
            r_ex_Jump     <= io_bus.id_Jump;
            r_ex_MemWr    <= io_bus.id_MemWr;
            r_ex_MemtoReg <= io_bus.id_MemtoReg;
            r_ex_ALUctr   <= io_bus.id_ALUctr;
            r_ex_rs       <= io_bus.id_rs;
            r_ex_rt       <= io_bus.id_rt;
            r_ex_rd       <= io_bus.id_rd;
            r_ex_wreg     <= io_bus.id_RegDst ? io_bus.id_rd : io_bus.id_rt;
        end
    end

    // ID/EX data words: zeroed in a bubble so a killed instruction leaves no trace
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_busA  <= {DATA_W{1'b0}};
            r_ex_busB  <= {DATA_W{1'b0}};
            r_ex_imm32 <= {DATA_W{1'b0}};
            r_ex_pc4   <= {DATA_W{1'b0}};
        end else if (w_bubble) begin
            r_ex_busA  <= {DATA_W{1'b0}};
            r_ex_busB  <= {DATA_W{1'b0}};
            r_ex_imm32 <= {DATA_W{1'b0}};
            r_ex_pc4   <= {DATA_W{1'b0}};
        end else begin
            r_ex_busA  <= io_bus.id_busA;
            r_ex_busB  <= io_bus.id_busB;
            r_ex_imm32 <= io_bus.id_imm32;
            r_ex_pc4   <= io_bus.id_pc4;
        end
    end

    // Stall counter: one count per inserted load-use bubble, holds at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    // Flush counter: one count per killed ID instruction, holds at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= {CNT_W{1'b0}};
        end else if (io_bus.flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end else begin
            r_flush_cnt <= r_flush_cnt;
        end
    end

    // Bubbles carry rs/rt = 0, so the forwarding unit reports 00 for them
    id_ex_stage_fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd_unit (
        .i_ex_rs       (r_ex_rs),
        .i_ex_rt       (r_ex_rt),
        .i_exmem_RegWr (io_bus.exmem_RegWr),
        .i_exmem_wreg  (io_bus.exmem_wreg),
        .i_memwb_RegWr (io_bus.memwb_RegWr),
        .i_memwb_wreg  (io_bus.memwb_wreg),
        .o_fwd_a       (w_fwd_a),
        .o_fwd_b       (w_fwd_b)
    );

    assign io_bus.pc_wr_en    = ~w_stall;
    assign io_bus.ifid_wr_en  = ~w_stall;

    assign io_bus.ex_RegWr    = r_ex_RegWr;
    assign io_bus.ex_RegDst   = r_ex_RegDst;
    assign io_bus.ex_ExtOp    = r_ex_ExtOp;
    assign io_bus.ex_ALUsrc   = r_ex_ALUsrc;
    assign io_bus.ex_Branch   = r_ex_Branch;
    assign io_bus.ex_Jump     = r_ex_Jump;
    assign io_bus.ex_MemWr    = r_ex_MemWr;
    assign io_bus.ex_MemtoReg = r_ex_MemtoReg;
    assign io_bus.ex_ALUctr   = r_ex_ALUctr;
    assign io_bus.ex_rs       = r_ex_rs;
    assign io_bus.ex_rt       = r_ex_rt;
    assign io_bus.ex_rd       = r_ex_rd;
    assign io_bus.ex_busA     = r_ex_busA;
    assign io_bus.ex_busB     = r_ex_busB;
    assign io_bus.ex_imm32    = r_ex_imm32;
    assign io_bus.ex_pc4      = r_ex_pc4;
    assign io_bus.ex_wreg     = r_ex_wreg;

    assign io_bus.fwd_a       = w_fwd_a;
    assign io_bus.fwd_b       = w_fwd_b;
    assign io_bus.stall_cnt   = r_stall_cnt;
    assign io_bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    typedef struct packed {
        logic        RegWr, RegDst, ExtOp, ALUsrc, Branch, Jump, MemWr, MemtoReg;
        logic [2:0]  ALUctr;
        logic [4:0]  rs, rt, rd;
        logic [31:0] busA, busB, imm, pc4;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    instr_t cur_in = '0;
    logic   cur_fl = 1'b0;
    logic   ew = 1'b0, mw = 1'b0;
    logic [4:0] er = 5'd0, mr = 5'd0;

    // Reference model: instruction held in EX (all-zero = bubble) and event counts
    instr_t m_ex = '0;
    int     m_stall = 0;
    int     m_flush = 0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.CNT_W(16)) bus ();
    id_ex_stage_if #(.CNT_W(2))  bus_s ();

    id_ex_stage #(.CNT_W(16)) dut   (.clk(clk), .rst_n(rst_n), .io_bus(bus));
    id_ex_stage #(.CNT_W(2))  dut_s (.clk(clk), .rst_n(rst_n), .io_bus(bus_s));

    assign bus.id_RegWr = cur_in.RegWr;     assign bus_s.id_RegWr = cur_in.RegWr;
    assign bus.id_RegDst = cur_in.RegDst;   assign bus_s.id_RegDst = cur_in.RegDst;
    assign bus.id_ExtOp = cur_in.ExtOp;     assign bus_s.id_ExtOp = cur_in.ExtOp;
    assign bus.id_ALUsrc = cur_in.ALUsrc;   assign bus_s.id_ALUsrc = cur_in.ALUsrc;
    assign bus.id_Branch = cur_in.Branch;   assign bus_s.id_Branch = cur_in.Branch;
    assign bus.id_Jump = cur_in.Jump;       assign bus_s.id_Jump = cur_in.Jump;
    assign bus.id_MemWr = cur_in.MemWr;     assign bus_s.id_MemWr = cur_in.MemWr;
    assign bus.id_MemtoReg = cur_in.MemtoReg; assign bus_s.id_MemtoReg = cur_in.MemtoReg;
    assign bus.id_ALUctr = cur_in.ALUctr;   assign bus_s.id_ALUctr = cur_in.ALUctr;
    assign bus.id_rs = cur_in.rs;           assign bus_s.id_rs = cur_in.rs;
    assign bus.id_rt = cur_in.rt;           assign bus_s.id_rt = cur_in.rt;
    assign bus.id_rd = cur_in.rd;           assign bus_s.id_rd = cur_in.rd;
    assign bus.id_busA = cur_in.busA;       assign bus_s.id_busA = cur_in.busA;
    assign bus.id_busB = cur_in.busB;       assign bus_s.id_busB = cur_in.busB;
    assign bus.id_imm32 = cur_in.imm;       assign bus_s.id_imm32 = cur_in.imm;
    assign bus.id_pc4 = cur_in.pc4;         assign bus_s.id_pc4 = cur_in.pc4;
    assign bus.flush = cur_fl;              assign bus_s.flush = cur_fl;
    assign bus.exmem_RegWr = ew;            assign bus_s.exmem_RegWr = ew;
    assign bus.exmem_wreg = er;             assign bus_s.exmem_wreg = er;
    assign bus.memwb_RegWr = mw;            assign bus_s.memwb_RegWr = mw;
    assign bus.memwb_wreg = mr;             assign bus_s.memwb_wreg = mr;

    // ---------------- instruction builders ----------------
    function automatic instr_t with_data(instr_t t);
        t.busA = $urandom; t.busB = $urandom; t.imm = $urandom; t.pc4 = $urandom;
        return t;
    endfunction

    function automatic instr_t mk_alu(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt, logic [2:0] op);
        instr_t t = '0;
        t.RegWr = 1'b1; t.RegDst = 1'b1; t.ALUctr = op;
        t.rs = rs; t.rt = rt; t.rd = rd;
        return with_data(t);
    endfunction

    function automatic instr_t mk_lw(logic [4:0] rt, logic [4:0] base);
        instr_t t = '0;
        t.RegWr = 1'b1; t.ALUsrc = 1'b1; t.ExtOp = 1'b1; t.MemtoReg = 1'b1;
        t.rs = base; t.rt = rt; t.rd = 5'($urandom);
        return with_data(t);
    endfunction

    function automatic instr_t mk_j(logic [4:0] rs, logic [4:0] rt);
        instr_t t = '0;
        t.Jump = 1'b1; t.rs = rs; t.rt = rt; t.rd = 5'($urandom);
        return with_data(t);
    endfunction

    function automatic instr_t rnd_instr();
        instr_t t;
        logic [4:0] a, b, c;
        a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); c = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0: t = mk_lw(a, b);
            1: t = mk_alu(a, b, c, 3'($urandom_range(0, 4)));
            2: t = mk_j(a, b);
            default: begin
                t = with_data('0);
                {t.RegWr, t.RegDst, t.ExtOp, t.ALUsrc, t.Branch, t.Jump, t.MemWr, t.MemtoReg} = 8'($urandom);
                t.ALUctr = 3'($urandom_range(0, 4)); t.rs = a; t.rt = b; t.rd = c;
            end
        endcase
        return t;
    endfunction

    // ---------------- reference rules ----------------
    // Which registers an instruction actually reads
    function automatic bit reads_reg(instr_t id, logic [4:0] r);
        return (!id.Jump && id.rs == r) || ((id.RegDst || id.MemWr || id.Branch) && id.rt == r);
    endfunction

    // A load in EX whose loaded register the ID instruction needs
    function automatic bit is_load_use(instr_t ex, instr_t id);
        return ex.MemtoReg && ex.RegWr && ex.rt != 5'd0 && reads_reg(id, ex.rt);
    endfunction

    function automatic logic [1:0] exp_fwd(logic [4:0] src);
        if (src != 5'd0 && ew && er == src) return 2'b10;
        if (src != 5'd0 && mw && mr == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [4:0] dest_of(instr_t t);
        return t.RegDst ? t.rd : t.rt;
    endfunction

    function automatic int sat(int v, int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    function automatic instr_t obs_ex();
        instr_t o;
        o.RegWr = bus.ex_RegWr; o.RegDst = bus.ex_RegDst; o.ExtOp = bus.ex_ExtOp;
        o.ALUsrc = bus.ex_ALUsrc; o.Branch = bus.ex_Branch; o.Jump = bus.ex_Jump;
        o.MemWr = bus.ex_MemWr; o.MemtoReg = bus.ex_MemtoReg; o.ALUctr = bus.ex_ALUctr;
        o.rs = bus.ex_rs; o.rt = bus.ex_rt; o.rd = bus.ex_rd;
        o.busA = bus.ex_busA; o.busB = bus.ex_busB; o.imm = bus.ex_imm32; o.pc4 = bus.ex_pc4;
        return o;
    endfunction

    // Advance model by one clock edge using the inputs currently applied
    task automatic tick();
        if (cur_fl) begin
            m_ex = '0; m_flush++;
        end else if (is_load_use(m_ex, cur_in)) begin
            m_ex = '0; m_stall++;
        end else begin
            m_ex = cur_in;
        end
        @(posedge clk); #1;
    endtask

    task automatic set_ls(logic a, logic [4:0] ar, logic b, logic [4:0] br);
        ew = a; er = ar; mw = b; mr = br;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cur_in = rnd_instr(); cur_fl = 1'($urandom);
            set_ls(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom));
            @(posedge clk); #2;
            total++; if (obs_ex() !== instr_t'('0)) begin bad++; $display("FAIL reset_ex got=%h exp=0", obs_ex()); end
            total++; if (bus.ex_wreg !== 5'd0 || bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
                bad++; $display("FAIL reset_regs wreg=%0d stall=%0d flush=%0d exp=0", bus.ex_wreg, bus.stall_cnt, bus.flush_cnt); end
            total++; if (bus.pc_wr_en !== 1'b1 || bus.ifid_wr_en !== 1'b1 || bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin
                bad++; $display("FAIL reset_comb pc=%b ifid=%b fa=%b fb=%b exp=1,1,00,00", bus.pc_wr_en, bus.ifid_wr_en, bus.fwd_a, bus.fwd_b); end
        end
        cur_in = '0; cur_fl = 1'b0; set_ls(1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        m_ex = '0; m_stall = 0; m_flush = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        cur_in = mk_alu(5'd3, 5'd1, 5'd2, ALU_ADD); #1;
        total++; if (bus.pc_wr_en !== 1'b1) begin bad++; $display("FAIL pass_pc got=%b exp=1", bus.pc_wr_en); end
        tick();
        total++; if (bus.ex_RegWr !== 1'b1 || bus.ex_wreg !== 5'd3 || bus.ex_ALUctr !== 3'b000) begin
            bad++; $display("FAIL pass_ctrl RegWr=%b wreg=%0d alu=%b exp=1,3,000", bus.ex_RegWr, bus.ex_wreg, bus.ex_ALUctr); end
        total++; if (obs_ex() !== m_ex) begin bad++; $display("FAIL pass_all got=%h exp=%h", obs_ex(), m_ex); end
    endtask

    task automatic test_load_use();
        instr_t add_i;
        cur_in = mk_lw(5'd2, 5'd1); tick();
        add_i = mk_alu(5'd4, 5'd2, 5'd3, ALU_ADD);
        cur_in = add_i; #1;
        total++; if (bus.pc_wr_en !== 1'b0 || bus.ifid_wr_en !== 1'b0) begin
            bad++; $display("FAIL lu_stall pc=%b ifid=%b exp=0,0", bus.pc_wr_en, bus.ifid_wr_en); end
        tick();
        total++; if (bus.ex_RegWr !== 1'b0 || bus.ex_MemtoReg !== 1'b0 || bus.stall_cnt !== 16'd1) begin
            bad++; $display("FAIL lu_bubble RegWr=%b MemtoReg=%b stall=%0d exp=0,0,1", bus.ex_RegWr, bus.ex_MemtoReg, bus.stall_cnt); end
        #1;
        total++; if (bus.pc_wr_en !== 1'b1) begin bad++; $display("FAIL lu_release pc=%b exp=1", bus.pc_wr_en); end
        tick();
        total++; if (bus.ex_wreg !== 5'd4 || obs_ex() !== add_i) begin
            bad++; $display("FAIL lu_issue wreg=%0d got=%h exp=%h", bus.ex_wreg, obs_ex(), add_i); end
    endtask

    task automatic test_no_false_stall();
        cur_in = mk_lw(5'd2, 5'd1); tick();
        cur_in = mk_j(5'd2, 5'd2); #1;
        total++; if (bus.pc_wr_en !== 1'b1) begin bad++; $display("FAIL nfs_jump pc=%b exp=1", bus.pc_wr_en); end
        tick();
        cur_in = mk_lw(5'd0, 5'd1); tick();
        cur_in = mk_alu(5'd4, 5'd0, 5'd3, ALU_ADD); #1;
        total++; if (bus.pc_wr_en !== 1'b1) begin bad++; $display("FAIL nfs_r0 pc=%b exp=1", bus.pc_wr_en); end
        tick();
        total++; if (bus.stall_cnt !== 16'd1 || bus.ex_wreg !== 5'd4) begin
            bad++; $display("FAIL nfs_cnt stall=%0d wreg=%0d exp=1,4", bus.stall_cnt, bus.ex_wreg); end
    endtask

    task automatic test_flush_vs_stall();
        cur_in = mk_lw(5'd2, 5'd1); tick();
        cur_in = mk_alu(5'd4, 5'd2, 5'd3, ALU_ADD); cur_fl = 1'b1; #1;
        total++; if (bus.pc_wr_en !== 1'b1 || bus.ifid_wr_en !== 1'b1) begin
            bad++; $display("FAIL fvs_pc pc=%b ifid=%b exp=1,1", bus.pc_wr_en, bus.ifid_wr_en); end
        tick();
        cur_fl = 1'b0;
        total++; if (obs_ex() !== instr_t'('0) || bus.flush_cnt !== 16'd1 || bus.stall_cnt !== 16'd1) begin
            bad++; $display("FAIL fvs_state ex=%h flush=%0d stall=%0d exp=0,1,1", obs_ex(), bus.flush_cnt, bus.stall_cnt); end
    endtask

    task automatic test_forwarding();
        cur_in = mk_alu(5'd7, 5'd5, 5'd6, ALU_OR); tick();
        cur_in = mk_alu(5'd9, 5'd1, 5'd1, ALU_AND);
        set_ls(1'b1, 5'd5, 1'b1, 5'd5); #1;
        total++; if (bus.fwd_a !== 2'b10 || bus.fwd_b !== 2'b00) begin
            bad++; $display("FAIL fwd_tie fa=%b fb=%b exp=10,00", bus.fwd_a, bus.fwd_b); end
        set_ls(1'b0, 5'd5, 1'b1, 5'd5); #1;
        total++; if (bus.fwd_a !== 2'b01) begin bad++; $display("FAIL fwd_memwb fa=%b exp=01", bus.fwd_a); end
        set_ls(1'b1, 5'd0, 1'b1, 5'd0); #1;
        total++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin
            bad++; $display("FAIL fwd_r0 fa=%b fb=%b exp=00,00", bus.fwd_a, bus.fwd_b); end
        set_ls(1'b1, 5'd6, 1'b1, 5'd6); #1;
        total++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b10) begin
            bad++; $display("FAIL fwd_b fa=%b fb=%b exp=00,10", bus.fwd_a, bus.fwd_b); end
        cur_fl = 1'b1; tick(); cur_fl = 1'b0;
        set_ls(1'b1, 5'd5, 1'b1, 5'd6); #1;
        total++; if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin
            bad++; $display("FAIL fwd_bubble fa=%b fb=%b exp=00,00", bus.fwd_a, bus.fwd_b); end
        set_ls(1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic test_random();
        bit lu;
        for (int i = 0; i < 400; i++) begin
            cur_in = rnd_instr();
            cur_fl = ($urandom_range(0, 9) == 0);
            set_ls(1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)));
            #1;
            lu = is_load_use(m_ex, cur_in) && !cur_fl;
            total++; if (bus.pc_wr_en !== !lu || bus.ifid_wr_en !== !lu || bus_s.pc_wr_en !== !lu) begin
                bad++; $display("FAIL rnd_pc i=%0d pc=%b ifid=%b exp=%b", i, bus.pc_wr_en, bus.ifid_wr_en, !lu); end
            total++; if (bus.fwd_a !== exp_fwd(m_ex.rs) || bus.fwd_b !== exp_fwd(m_ex.rt)) begin
                bad++; $display("FAIL rnd_fwd i=%0d fa=%b fb=%b exp=%b,%b", i, bus.fwd_a, bus.fwd_b, exp_fwd(m_ex.rs), exp_fwd(m_ex.rt)); end
            tick();
            total++; if (obs_ex() !== m_ex || bus.ex_wreg !== dest_of(m_ex)) begin
                bad++; $display("FAIL rnd_ex i=%0d got=%h wreg=%0d exp=%h wreg=%0d", i, obs_ex(), bus.ex_wreg, m_ex, dest_of(m_ex)); end
            total++; if (bus.stall_cnt !== 16'(sat(m_stall, 16)) || bus.flush_cnt !== 16'(sat(m_flush, 16))
                         || bus_s.stall_cnt !== 2'(sat(m_stall, 2)) || bus_s.flush_cnt !== 2'(sat(m_flush, 2))) begin
                bad++; $display("FAIL rnd_cnt i=%0d stall=%0d/%0d flush=%0d/%0d exp=%0d/%0d %0d/%0d", i,
                    bus.stall_cnt, bus_s.stall_cnt, bus.flush_cnt, bus_s.flush_cnt,
                    sat(m_stall, 16), sat(m_stall, 2), sat(m_flush, 16), sat(m_flush, 2)); end
        end
        cur_fl = 1'b0; set_ls(1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic test_reset_mid_stall_and_saturation();
        cur_in = mk_lw(5'd2, 5'd1); tick();
        cur_in = mk_alu(5'd4, 5'd2, 5'd3, ALU_ADD); #1;
        total++; if (bus.pc_wr_en !== 1'b0) begin bad++; $display("FAIL mid_pre pc=%b exp=0", bus.pc_wr_en); end
        rst_n = 1'b0; #1;
        total++; if (bus.pc_wr_en !== 1'b1 || obs_ex() !== instr_t'('0) || bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
            bad++; $display("FAIL mid_reset pc=%b ex=%h stall=%0d flush=%0d exp=1,0,0,0", bus.pc_wr_en, obs_ex(), bus.stall_cnt, bus.flush_cnt); end
        @(negedge clk); rst_n = 1'b1;
        m_ex = '0; m_stall = 0; m_flush = 0;
        #1;
        total++; if (bus.pc_wr_en !== 1'b1) begin bad++; $display("FAIL mid_release pc=%b exp=1", bus.pc_wr_en); end
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            cur_in = mk_lw(5'd2, 5'd1); tick();
            cur_in = mk_alu(5'd4, 5'd2, 5'd3, ALU_SUB); tick(); tick();
        end
        total++; if (bus_s.stall_cnt !== 2'd3 || bus.stall_cnt !== 16'd5) begin
            bad++; $display("FAIL sat_stall small=%0d big=%0d exp=3,5", bus_s.stall_cnt, bus.stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_use();
        test_no_false_stall();
        test_flush_vs_stall();
        test_forwarding();
        test_random();
        test_reset_mid_stall_and_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
